// File: rtl/pc_unit_ras.sv
// pc_unit_ras
//   Program-counter unit with relative branch, absolute jump, call/return
//   through a small circular return-address stack (RAS), stall, and a
//   configurable reset vector. Instruction memory is word addressed, so the
//   sequential step is +1.
//
// Parameters
//   AW        PC / target width in bits
//   RESET_PC  PC value loaded on reset
//   RAS_DEPTH return-address stack entries (power of two, >= 2)
//   CW        ras_count width, derived
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous active-high reset, overrides stall
//   stall         hold all state, ignore every request, flags low
//   branch_en     relative branch, pc <= pc + 1 + branch_off
//   branch_off    two's-complement word offset
//   jump_en       pc <= jump_tgt, RAS untouched
//   call_en       pc <= jump_tgt, push pc + 1
//   jump_tgt      absolute target for jump and call
//   ret_en        pop RAS top into pc (pc + 1 and underflow flag if empty)
//   pc            registered current PC
//   ras_count     number of valid RAS entries, 0..RAS_DEPTH
//   ras_overflow  one-cycle pulse: push onto a full RAS
//   ras_underflow one-cycle pulse: pop from an empty RAS
module pc_unit_ras #(
  parameter int            AW        = 32,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter int            RAS_DEPTH = 4,
  localparam int           CW        = $clog2(RAS_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          branch_en,
  input  logic [AW-1:0] branch_off,
  input  logic          jump_en,
  input  logic          call_en,
  input  logic [AW-1:0] jump_tgt,
  input  logic          ret_en,
  output logic [AW-1:0] pc,
  output logic [CW-1:0] ras_count,
  output logic          ras_overflow,
  output logic          ras_underflow
);

  localparam int PW = $clog2(RAS_DEPTH);

  logic [AW-1:0] pc_q, pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [PW-1:0] sp_q, sp_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic [AW-1:0] ras_q [RAS_DEPTH];
  logic [AW-1:0] ras_d [RAS_DEPTH];

  logic [AW-1:0] pc_inc;
  logic [PW-1:0] sp_inc;
  logic [PW-1:0] sp_dec;
  logic          ras_full;
  logic          ras_empty;

  // sp_q is the next free slot; the top of stack sits one below it.
  // Both wrap modulo RAS_DEPTH because the depth is a power of two, so a
  // push onto a full stack lands on the oldest entry and overwrites it.
  assign pc_inc    = pc_q + AW'(1);
  assign sp_inc    = sp_q + PW'(1);
  assign sp_dec    = sp_q - PW'(1);
  assign ras_full  = (count_q == CW'(RAS_DEPTH));
  assign ras_empty = (count_q == '0);

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    sp_d    = sp_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    ras_d   = ras_q;

    if (reset) begin
      pc_d    = RESET_PC;
      count_d = '0;
      sp_d    = '0;
    end else if (!stall) begin
      // Fixed priority ret > call > jump > branch > sequential; losers of
      // the same cycle are simply dropped.
      if (ret_en) begin
        if (!ras_empty) begin
          pc_d    = ras_q[sp_dec];
          sp_d    = sp_dec;
          count_d = count_q - CW'(1);
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (call_en) begin
        pc_d        = jump_tgt;
        ras_d[sp_q] = pc_inc;
        sp_d        = sp_inc;
        if (ras_full) begin
          ovf_d = 1'b1;
        end else begin
          count_d = count_q + CW'(1);
        end
      end else if (jump_en) begin
        pc_d = jump_tgt;
      end else if (branch_en) begin
        pc_d = pc_inc + branch_off;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  // Control state; reset is folded into the next-state logic above.
  always_ff @(posedge clk) begin
    pc_q    <= pc_d;
    count_q <= count_d;
    sp_q    <= sp_d;
    ovf_q   <= ovf_d;
    unf_q   <= unf_d;
  end

  // Stack storage carries no reset; entries are only read once pushed.
  always_ff @(posedge clk) begin
    ras_q <= ras_d;
  end

  assign pc            = pc_q;
  assign ras_count     = count_q;
  assign ras_overflow  = ovf_q;
  assign ras_underflow = unf_q;

endmodule
